// File: rtl/fifo_ram_dma.sv
// fifo_ram_dma: drains a programmed number of FIFO words into consecutive RAM
// addresses starting at a programmed base. It shares the RAM write port with
// SPI-host writes, and host writes always win.
module fifo_ram_dma #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   xfer_cnt,
   output logic              fifo_rreq,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              fifo_rempty,
   input  logic              host_wreq,
   input  logic [ADDR_W-1:0] host_waddr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              ram_wreq,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]        state, state_nxt;
   logic              busy_nxt, done_nxt;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  len, len_sat, issued;
   logic              hold_vld, inflight;
   logic [DATA_W-1:0] hold_data;
   logic              dma_wr, hold_free, start_ok;

   assign len_sat  = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
   assign start_ok = en && cfg_start && (state == S_IDLE);

   // State, busy and done registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next state, RAM port arbitration and FIFO read issue
   always_comb begin
      state_nxt = state;
      fifo_rreq = 1'b0;
      ram_wreq  = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      dma_wr    = 1'b0;
      hold_free = 1'b0;
      if (en) begin
         if (host_wreq) begin
            ram_wreq  = 1'b1;
            ram_waddr = host_waddr;
            ram_wdata = host_wdata;
         end else if (hold_vld) begin
            dma_wr    = 1'b1;
            ram_wreq  = 1'b1;
            ram_waddr = base + xfer_cnt[ADDR_W-1:0];
            ram_wdata = hold_data;
         end
         // A hold slot draining this cycle can accept the next read, giving 2-cycle throughput
         hold_free = !hold_vld || dma_wr;
         case (state)
            S_IDLE: begin
               if (cfg_start) state_nxt = (cfg_len == '0) ? S_FIN : S_RUN;
            end
            S_RUN: begin
               if ((issued < len) && !fifo_rempty && hold_free && !inflight) fifo_rreq = 1'b1;
               if (issued == len) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
               if (hold_free && !inflight) state_nxt = S_FIN;
            end
            default: state_nxt = S_IDLE;
         endcase
      end else begin
         state_nxt = S_IDLE;
      end
      busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done_nxt = (state_nxt == S_FIN);
   end

   // Transfer parameters, counters and the one-entry hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base      <= '0;
         len       <= '0;
         issued    <= '0;
         xfer_cnt  <= '0;
         inflight  <= 1'b0;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else begin
         if (start_ok) begin
            base     <= cfg_base;
            len      <= len_sat;
            issued   <= '0;
            xfer_cnt <= '0;
         end else begin
            if (fifo_rreq) issued   <= issued + LEN_W'(1);
            if (dma_wr)    xfer_cnt <= xfer_cnt + LEN_W'(1);
         end
         inflight <= fifo_rreq;
         if (!en) begin
            hold_vld <= 1'b0;
         end else if (inflight) begin
            hold_vld  <= 1'b1;
            hold_data <= fifo_rdata;
         end else if (dma_wr) begin
            hold_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_ram_dma.sv
// Bench for fifo_ram_dma: FIFO and RAM models, expected RAM image and write order.
module tb_fifo_ram_dma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cfg_start = 1'b0;
   logic [7:0]  cfg_base = '0;
   logic [8:0]  cfg_len = '0;
   logic        busy, done;
   logic [8:0]  xfer_cnt;
   logic        fifo_rreq;
   logic [15:0] fifo_rdata = '0;
   logic        fifo_rempty;
   logic        host_wreq = 1'b0;
   logic [7:0]  host_waddr = '0;
   logic [15:0] host_wdata = '0;
   logic        ram_wreq;
   logic [7:0]  ram_waddr;
   logic [15:0] ram_wdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_ram_dma #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_start(cfg_start),
      .cfg_base(cfg_base), .cfg_len(cfg_len), .busy(busy), .done(done),
      .xfer_cnt(xfer_cnt), .fifo_rreq(fifo_rreq), .fifo_rdata(fifo_rdata),
      .fifo_rempty(fifo_rempty), .host_wreq(host_wreq), .host_waddr(host_waddr),
      .host_wdata(host_wdata), .ram_wreq(ram_wreq), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata)
   );

   // FIFO model: data valid one cycle after a read request
   logic [15:0] fmem [0:1023];
   int unsigned f_wr = 0;
   int unsigned f_rd = 0;
   bit          f_flush = 1'b0;
   int unsigned empty_rd = 0;
   assign fifo_rempty = (f_wr == f_rd);

   always @(posedge clk) begin
      if (f_flush) f_rd <= f_wr;
      else if (fifo_rreq) begin
         if (f_wr == f_rd) empty_rd <= empty_rd + 1;
         else begin
            fifo_rdata <= fmem[10'(f_rd)];
            f_rd <= f_rd + 1;
         end
      end
   end

   // RAM model plus write log and event counters
   logic [15:0] ram [0:255];
   logic [7:0]  log_a [0:4095];
   logic [15:0] log_d [0:4095];
   int unsigned wr_n = 0;
   int unsigned done_cnt = 0;
   int unsigned rreq_cnt = 0;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (fifo_rreq) rreq_cnt <= rreq_cnt + 1;
      if (ram_wreq) begin
         ram[ram_waddr] <= ram_wdata;
         log_a[12'(wr_n)] <= ram_waddr;
         log_d[12'(wr_n)] <= ram_wdata;
         wr_n <= wr_n + 1;
      end
   end

   // Reference: expected RAM image and expected write sequence
   logic [15:0] exp_ram [0:255];
   bit          exp_v [0:255];
   logic [7:0]  exp_la [0:1023];
   logic [15:0] exp_ld [0:1023];
   int          exp_n = 0;
   logic [15:0] cur_words [$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      fmem[10'(f_wr)] = w;
      f_wr = f_wr + 1;
      cur_words.push_back(w);
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) push(16'($urandom));
   endtask

   task automatic flush;
      f_flush = 1'b1;
      tick();
      f_flush = 1'b0;
   endtask

   task automatic new_xfer;
      cur_words.delete();
      exp_n = 0;
   endtask

   task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
      exp_ram[a] = d;
      exp_v[a] = 1'b1;
      exp_la[exp_n] = a;
      exp_ld[exp_n] = d;
      exp_n++;
   endtask

   task automatic expect_dma(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) expect_wr(base + 8'(i), cur_words[i]);
   endtask

   task automatic check_ram(input string tag);
      int bad = 0;
      for (int a = 0; a < 256; a++)
         if (exp_v[a] && (ram[a] !== exp_ram[a])) bad++;
      chk(tag, 32'(bad), 32'd0);
   endtask

   task automatic check_log(input string tag, input int unsigned log0);
      int bad = 0;
      chk({tag, "_count"}, wr_n - log0, 32'(exp_n));
      for (int i = 0; i < exp_n; i++)
         if ((log_a[12'(log0 + 32'(i))] !== exp_la[i]) || (log_d[12'(log0 + 32'(i))] !== exp_ld[i])) bad++;
      chk({tag, "_order"}, 32'(bad), 32'd0);
   endtask

   task automatic wait_done(input int budget, output int got);
      got = -1;
      for (int k = 0; k <= budget; k++) begin
         if (done) begin
            got = k;
            break;
         end
         tick();
      end
   endtask

   // Start a transfer of words already loaded, optional host burst and ignored restart
   task automatic run_xfer(input string tag, input logic [7:0] base, input logic [8:0] len,
                           input int n, input int host_at, input int host_n,
                           input int poke_at, input int exp_lat);
      int unsigned log0 = wr_n;
      int unsigned d0 = done_cnt;
      int got = -1;
      cfg_base = base;
      cfg_len = len;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_base = 8'($urandom);
      cfg_len = 9'($urandom);
      chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      for (int k = 1; k <= 2000; k++) begin
         if (done) begin
            got = k;
            break;
         end
         if (k >= host_at && k < host_at + host_n) begin
            host_wreq = 1'b1;
            host_waddr = base + 8'd128 + 8'(k);
            host_wdata = 16'($urandom);
            expect_wr(host_waddr, host_wdata);
         end else host_wreq = 1'b0;
         cfg_start = (k == poke_at);
         tick();
      end
      host_wreq = 1'b0;
      cfg_start = 1'b0;
      expect_dma(base, n);
      chk({tag, "_latency"}, 32'(got), 32'(exp_lat));
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
      tick();
      tick();
      tick();
      chk({tag, "_done_once"}, done_cnt - d0, 32'd1);
      chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(n));
      check_ram({tag, "_ram"});
      check_log(tag, log0);
   endtask

   initial begin
      int got;
      int unsigned log0, d0, r0;
      logic [7:0] b;
      int n;

      // Reset values
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rreq", 32'(fifo_rreq), 32'd0);
      chk("rst_wreq", 32'(ram_wreq), 32'd0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      chk("rst_waddr", 32'(ram_waddr), 32'd0);
      rst_n = 1'b1;
      en = 1'b1;
      tick();

      // Basic transfer
      new_xfer();
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      run_xfer("basic", 8'h10, 9'd4, 4, 0, 0, 0, 10);

      // Address wrap
      new_xfer();
      load(4);
      run_xfer("wrap", 8'hFE, 9'd4, 4, 0, 0, 0, 10);

      // Host priority: 3 host cycles from the first DMA write slot
      new_xfer();
      load(4);
      run_xfer("host", 8'h20, 9'd4, 4, 3, 3, 0, 13);

      // Starvation
      new_xfer();
      load(1);
      log0 = wr_n;
      d0 = done_cnt;
      cfg_base = 8'h50;
      cfg_len = 9'd3;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      repeat (20) tick();
      chk("starve_busy", 32'(busy), 32'd1);
      chk("starve_xfer_cnt", 32'(xfer_cnt), 32'd1);
      chk("starve_no_done", done_cnt - d0, 32'd0);
      load(2);
      wait_done(100, got);
      chk("starve_latency", 32'(got), 32'd5);
      tick();
      chk("starve_xfer_cnt_end", 32'(xfer_cnt), 32'd3);
      expect_dma(8'h50, 3);
      check_ram("starve_ram");
      check_log("starve", log0);

      // Zero length: done next cycle, no FIFO reads, no RAM writes
      new_xfer();
      load(1);
      r0 = rreq_cnt;
      log0 = wr_n;
      d0 = done_cnt;
      cfg_len = 9'd0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_xfer_cnt", 32'(xfer_cnt), 32'd0);
      repeat (4) tick();
      chk("zero_no_rreq", rreq_cnt - r0, 32'd0);
      chk("zero_no_wreq", wr_n - log0, 32'd0);
      chk("zero_done_once", done_cnt - d0, 32'd1);
      flush();

      // Start while busy is ignored
      new_xfer();
      load(8);
      run_xfer("poke", 8'h60, 9'd8, 8, 0, 0, 5, 18);

      // Random transfers
      for (int it = 0; it < 6; it++) begin
         new_xfer();
         n = 1 + int'($urandom_range(11));
         b = 8'($urandom);
         load(n);
         run_xfer("rand", b, 9'(n), n, 0, 0, 0, 2 * n + 2);
      end

      // Length above 256 saturates
      new_xfer();
      load(256);
      run_xfer("sat", 8'($urandom), 9'd300, 256, 0, 0, 0, 514);

      // Abort via en after 2 of 6 words
      new_xfer();
      load(6);
      log0 = wr_n;
      d0 = done_cnt;
      cfg_base = 8'h30;
      cfg_len = 9'd6;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      got = -1;
      for (int k = 0; k < 100; k++) begin
         if (xfer_cnt == 9'd2) begin
            got = k;
            break;
         end
         tick();
      end
      chk("abort_reached", 32'(got >= 0), 32'd1);
      en = 1'b0;
      host_wreq = 1'b1;
      host_waddr = 8'h77;
      host_wdata = 16'hBEEF;
      #1;
      chk("abort_wreq_gated", 32'(ram_wreq), 32'd0);
      chk("abort_rreq", 32'(fifo_rreq), 32'd0);
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_wreq_next", 32'(ram_wreq), 32'd0);
      host_wreq = 1'b0;
      en = 1'b1;
      repeat (5) tick();
      chk("abort_no_done", done_cnt - d0, 32'd0);
      chk("abort_xfer_cnt", 32'(xfer_cnt), 32'd2);
      expect_dma(8'h30, 2);
      check_ram("abort_ram");
      check_log("abort", log0);
      flush();

      // Reset mid-transfer, during the second DMA write
      new_xfer();
      load(6);
      cfg_base = 8'h40;
      cfg_len = 9'd6;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      repeat (4) tick();
      chk("midrst_pre_wreq", 32'(ram_wreq), 32'd1);
      chk("midrst_pre_waddr", 32'(ram_waddr), 32'h41);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_rreq", 32'(fifo_rreq), 32'd0);
      chk("midrst_wreq", 32'(ram_wreq), 32'd0);
      chk("midrst_waddr", 32'(ram_waddr), 32'd0);
      chk("midrst_wdata", 32'(ram_wdata), 32'd0);
      chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      flush();
      tick();

      chk("fifo_underflow", empty_rd, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_ram_dma.md
# fifo_ram_dma

Sequencer that drains a programmed number of 16-bit words from the on-chip FIFO into consecutive RAM addresses, starting at a programmed base address. It sits between the SPI sram-like interface and the `fpga_fifo`/`fpga_ram` instances in `design_main`. It owns the FIFO read port and shares the single RAM write port with SPI-host writes, which always take priority.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: data width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low aborts any transfer and forces idle.
- `cfg_start`  in  1  single-cycle start pulse.
- `cfg_base`  in  ADDR_W  first RAM address; sampled at start.
- `cfg_len`  in  ADDR_W+1  number of words, 0..256; sampled at start.
- `busy`  out  1  high while a transfer is active.
- `done`  out  1  one-cycle pulse after the last word is written.
- `xfer_cnt`  out  ADDR_W+1  number of words written to RAM in the current or last transfer.
- `fifo_rreq`  out  1  FIFO read request.
- `fifo_rdata`  in  DATA_W  FIFO data, valid one cycle after `fifo_rreq`.
- `fifo_rempty`  in  1  FIFO empty flag.
- `host_wreq`, `host_waddr`, `host_wdata`  in  1/ADDR_W/DATA_W  SPI-host RAM write.
- `ram_wreq`, `ram_waddr`, `ram_wdata`  out  1/ADDR_W/DATA_W  arbitrated RAM write port.

## Operation
States:
- **IDLE**: waiting for a start.
- **RUN**: fetching words from the FIFO and writing them to RAM.
- **DRAIN**: all reads issued; waiting for the last held word to be written.
- **FIN**: one cycle that asserts `done`, then returns to IDLE.

Start and length:
- IDLE→RUN on `cfg_start` with `en`=1 and `cfg_len`≠0.
- `cfg_start` with `cfg_len`=0: no transfer, but `done` pulses the next cycle and `xfer_cnt` is cleared to 0.
- `cfg_start` while `busy` is ignored.
- A start clears `xfer_cnt` and the internal `issued` counter.
- `cfg_len` > 256 saturates to 256.

Read issue in RUN:
- `fifo_rreq`=1 when all of the following hold: `issued` < len, `fifo_rempty`=0, the hold register is empty, and no read is in flight.
- Each issued read increments `issued`.
- The next cycle, `fifo_rdata` is captured into a one-entry hold register.

Write arbitration (every cycle):
- If `host_wreq`=1: the RAM port carries the host address and data, and the held word waits.
- Otherwise, if the hold register is full: write the held word at address `cfg_base` + `xfer_cnt` (mod 2^ADDR_W, so the address wraps 255→0), clear the hold register, and increment `xfer_cnt`.

Completion:
- RUN→DRAIN when `issued` = len.
- DRAIN→FIN when the hold register is empty and no read is in flight.
- FIN→IDLE unconditionally.

Enable and reset:
- `en`=0 in any state: go to IDLE next cycle, drop the hold register, `fifo_rreq`=0, no `done`.
- `en`=0 also gates the host path: `ram_wreq` = 0.
- A read already in flight when `en` falls is discarded (that word is lost; this is documented behaviour).
- Reset values: state IDLE; `busy`, `done`, `fifo_rreq`, `ram_wreq` = 0; `ram_waddr`, `ram_wdata`, `xfer_cnt` = 0; hold register empty.

## Timing
- `fifo_rreq` and `ram_*` are combinational from registered state, plus `host_*`/`fifo_rempty`/`en`. `busy` and `done` are registered.
- `busy` rises the cycle after the accepted `cfg_start` and falls in the same cycle `done` is high.
- Throughput without host contention: one word every 2 cycles (read in cycle t, capture at t+1, RAM write at t+2 overlapping the next read at t+2).
- Latency for N words with a non-empty FIFO and no host writes: `done` at start+2N+2.
- Each host write cycle delays the pending DMA write by one cycle. The hold register blocks further reads, so no word is lost or reordered.
- FIFO empty mid-transfer: RUN stalls indefinitely. There is no timeout; software aborts via `en`.

## Test plan
- **Basic transfer**: FIFO preloaded with 0x1111..0x4444, base=0x10, len=4, start → RAM[0x10..0x13] = 0x1111..0x4444; `done` pulses once at cycle start+10; `xfer_cnt`=4.
- **Address wrap**: base=0xFE, len=4, FIFO holds A,B,C,D → A@0xFE, B@0xFF, C@0x00, D@0x01.
- **Host priority**: `host_wreq` held high for 3 cycles starting at the first DMA write slot → the 3 host writes land unchanged; DMA writes all occur afterwards, in order; `xfer_cnt` reaches 4; `done` is delayed by exactly 3 cycles.
- **Starvation**: len=3 with only 1 word in the FIFO → `busy` stays high and `xfer_cnt`=1; push 2 more words → `done` pulses and `xfer_cnt`=3.
- **Zero length / start while busy**: len=0 start → `done` the next cycle, no `fifo_rreq`, no `ram_wreq`. A second `cfg_start` during a len=8 transfer is ignored and exactly 8 words are written.
- **Abort**: drop `en` after 2 of 6 words are written → IDLE next cycle, `ram_wreq`=0, no `done`. Assert `rst_n`=0 mid-transfer → all outputs at their reset values immediately.
